// File: rtl/btb_predictor_pkg.sv
// btb_predictor_pkg: shared definitions for the branch target buffer.
//   - direction counter encodings (2-bit names, plus width-generic helpers
//     that place "weak" states around the counter MSB)
//   - index-width function and PC index/tag slice helpers
// The slice helpers work on a 64-bit widened PC; callers cast the result
// down to their own index/tag width.
package btb_predictor_pkg;

  // Canonical names for the 2-bit case.
  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr2_e;

  // Weakly-not-taken: all ones below the MSB (01 for 2 bits, 011 for 3).
  function automatic int unsigned ctr_weak_nt(int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Weakly-taken: only the MSB set (10 for 2 bits, 100 for 3).
  function automatic int unsigned ctr_weak_t(int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  function automatic int unsigned idx_width(int unsigned entries);
    return $clog2(entries);
  endfunction

  // PC bits [1:0] are word offset and never take part in index or tag.
  function automatic logic [63:0] pc_index(logic [63:0] pc, int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(logic [63:0] pc, int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// sat_counter: combinational next-value for an up/down saturating counter.
//   ctr_i  current counter value
//   up_i   1 = count up (taken), 0 = count down (not taken)
//   ctr_o  next value, held at 0 and at all-ones
module sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters, used in IF to predict the next PC.
//   clk_i, rst_i           clock (rising edge); async active-low reset
//   pc_i                   IF-stage PC, looked up combinationally
//   hit_o                  valid entry with matching tag
//   pred_taken_o           hit_o and counter MSB set
//   pred_target_o          stored target, 0 on miss
//   upd_valid_i/upd_pc_i/upd_taken_i/upd_target_i
//                          ID-stage resolution used for training
//   upd_stall_i            hazard stall: update ignored, stats frozen
//   inval_i                clear all valid bits (drops same-cycle update)
//   lookup_cnt_o/hit_cnt_o saturating lookup and hit statistics
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_stall_i,
  input  logic              inval_i,
  output logic [CNT_W-1:0]  lookup_cnt_o,
  output logic [CNT_W-1:0]  hit_cnt_o
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_t(CTR_W));

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Entry storage
  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [CNT_W-1:0]   lookup_cnt_q, lookup_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

  // ---------------------------------------------------------------------
  // Lookup: purely combinational from registered state
  // ---------------------------------------------------------------------
  idx_t lk_idx;
  tag_t lk_tag;
  logic lk_hit;

  assign lk_idx = idx_t'(pc_index(64'(pc_i), IDX_W));
  assign lk_tag = tag_t'(pc_tag(64'(pc_i), IDX_W));
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign hit_o         = lk_hit;
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target_o = lk_hit ? target_q[lk_idx] : '0;

  // ---------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------
  idx_t             upd_idx;
  tag_t             upd_tag;
  logic             upd_hit;
  logic             upd_en;
  logic             wr_entry;   // tag/target/valid write (taken outcome)
  logic             wr_ctr;
  logic [CTR_W-1:0] ctr_next;
  logic [CTR_W-1:0] ctr_wdata;

  assign upd_idx = idx_t'(pc_index(64'(upd_pc_i), IDX_W));
  assign upd_tag = tag_t'(pc_tag(64'(upd_pc_i), IDX_W));
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Invalidation takes priority: the update is dropped entirely.
  assign upd_en = upd_valid_i && !upd_stall_i && !inval_i;

  sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .ctr_i (ctr_q[upd_idx]),
    .up_i  (upd_taken_i),
    .ctr_o (ctr_next)
  );

  // Taken outcomes write tag/target on a hit (same tag, new target) and
  // on a miss (allocation over whatever entry sits at this index).
  assign wr_entry  = upd_en && upd_taken_i;
  assign wr_ctr    = upd_en && (upd_hit || upd_taken_i);
  assign ctr_wdata = upd_hit ? ctr_next : CTR_ALLOC;

  always_comb begin
    valid_d = valid_q;
    if (inval_i) begin
      valid_d = '0;
    end else if (wr_entry) begin
      valid_d[upd_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else begin
      valid_q <= valid_d;
      if (wr_entry) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
      end
      if (wr_ctr) begin
        ctr_q[upd_idx] <= ctr_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics: count non-stalled cycles and their hits, saturating
  // ---------------------------------------------------------------------
  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    if (!upd_stall_i) begin
      if (lookup_cnt_q != '1) lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
      if (lk_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign lookup_cnt_o = lookup_cnt_q;
  assign hit_cnt_o    = hit_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Testbench for btb_predictor (default parameters: 32-bit PC, 16 entries,
// 2-bit counters, 16-bit statistics). A behavioural model tracks the BTB
// as a table keyed by word address: entry = (pc/4) mod 16, tag = pc/64.
module tb_btb_predictor;

  localparam int unsigned NENT   = 16;
  localparam int unsigned CNTMAX = 65535;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_stall_i;
  logic        inval_i;
  logic [15:0] lookup_cnt_o;
  logic [15:0] hit_cnt_o;

  int checks = 0;
  int errors = 0;

  btb_predictor #(
    .ADDR_W  (32),
    .ENTRIES (16),
    .CTR_W   (2),
    .CNT_W   (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .hit_o         (hit_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .upd_stall_i   (upd_stall_i),
    .inval_i       (inval_i),
    .lookup_cnt_o  (lookup_cnt_o),
    .hit_cnt_o     (hit_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];   // 0..3, predicts taken when >= 2
  int unsigned m_lk;
  int unsigned m_hc;

  function automatic int unsigned m_index(logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == pc / 64);
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_index(pc)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_lk = 0;
    m_hc = 0;
  endtask

  // Applies one rising edge to the model, using the inputs as driven.
  task automatic model_edge();
    int unsigned i;
    if (!rst_i) return;
    if (!upd_stall_i) begin
      if (m_lk < CNTMAX) m_lk++;
      if (m_hit(pc_i) && m_hc < CNTMAX) m_hc++;
    end
    if (inval_i) begin
      for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
    end else if (upd_valid_i && !upd_stall_i) begin
      i = m_index(upd_pc_i);
      if (m_hit(upd_pc_i)) begin
        if (upd_taken_i) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = upd_target_i;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (upd_taken_i) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upd_pc_i / 64;
        m_tgt[i]   = upd_target_i;
        m_ctr[i]   = 2;
      end
    end
  endtask

  // Inputs are driven after a falling edge; this advances one full cycle.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle();
    upd_valid_i  = 1'b0;
    upd_taken_i  = 1'b0;
    upd_pc_i     = '0;
    upd_target_i = '0;
    upd_stall_i  = 1'b0;
    inval_i      = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input bit taken,
                           input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b0;
    pc_i  = 32'h40;
    idle();
    model_reset();
    repeat (3) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_lookup: hit=%0b taken=%0b tgt=%h want 0 0 0",
                 hit_o, pred_taken_o, pred_target_o);
      end
      checks++;
      if (lookup_cnt_o !== 16'h0 || hit_cnt_o !== 16'h0) begin
        errors++;
        $display("FAIL reset_stats: lookups=%0d hits=%0d want 0 0",
                 lookup_cnt_o, hit_cnt_o);
      end
    end
    rst_i = 1'b1;
  endtask

  task automatic test_taken_alloc();
    pc_i = 32'h40;
    drive_upd(32'h40, 1'b1, 32'h80);
    #1;
    checks++;
    if (hit_o !== 1'b0) begin
      errors++;
      $display("FAIL alloc_pre_miss: hit=%0b want 0", hit_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin
      errors++;
      $display("FAIL alloc_hit: hit=%0b taken=%0b tgt=%h want 1 1 00000080",
               hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_counter_saturate();
    bit exp_taken [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    // 10 -> 01 -> 00 -> 00 (saturated), all predicting not-taken
    for (int n = 0; n < 3; n++) begin
      pc_i = 32'h40;
      drive_upd(32'h40, 1'b0, 32'h0);
      tick();
      idle();
      #1;
      checks++;
      if (hit_o !== 1'b1 || pred_taken_o !== exp_taken[n]) begin
        errors++;
        $display("FAIL ctr_down_%0d: hit=%0b taken=%0b want 1 %0b",
                 n, hit_o, pred_taken_o, exp_taken[n]);
      end
    end
    // 00 + taken -> 01 (a wrapped counter would read 11 and predict taken)
    drive_upd(32'h40, 1'b1, 32'h80);
    tick();
    idle();
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h80) begin
      errors++;
      $display("FAIL ctr_floor: taken=%0b tgt=%h want 0 00000080",
               pred_taken_o, pred_target_o);
    end
    drive_upd(32'h40, 1'b1, 32'h80);
    tick();
    idle();
    #1;
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++;
      $display("FAIL ctr_up_to_wt: taken=%0b want 1", pred_taken_o);
    end
  endtask

  task automatic test_alias();
    drive_upd(32'h440, 1'b1, 32'h100);
    tick();
    idle();
    pc_i = 32'h40;
    #1;
    checks++;
    if (hit_o !== 1'b0 || pred_target_o !== 32'h0) begin
      errors++;
      $display("FAIL alias_old_miss: hit=%0b tgt=%h want 0 00000000",
               hit_o, pred_target_o);
    end
    pc_i = 32'h440;
    #1;
    checks++;
    if (hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h100) begin
      errors++;
      $display("FAIL alias_new_hit: hit=%0b taken=%0b tgt=%h want 1 1 00000100",
               hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle_and_stall();
    pc_i = 32'h440;
    drive_upd(32'h440, 1'b1, 32'h200);
    #1;
    checks++;
    if (pred_target_o !== 32'h100) begin
      errors++;
      $display("FAIL same_cycle_old: tgt=%h want 00000100", pred_target_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pred_target_o !== 32'h200) begin
      errors++;
      $display("FAIL same_cycle_new: tgt=%h want 00000200", pred_target_o);
    end
    drive_upd(32'h440, 1'b1, 32'h300);
    upd_stall_i = 1'b1;
    tick();
    drive_upd(32'h440, 1'b0, 32'h0);
    upd_stall_i = 1'b1;
    tick();
    drive_upd(32'h440, 1'b0, 32'h0);
    upd_stall_i = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin
      errors++;
      $display("FAIL stall_ignored: hit=%0b taken=%0b tgt=%h want 1 1 00000200",
               hit_o, pred_taken_o, pred_target_o);
    end
    checks++;
    if (lookup_cnt_o !== 16'(m_lk) || hit_cnt_o !== 16'(m_hc)) begin
      errors++;
      $display("FAIL stall_stats: lookups=%0d hits=%0d want %0d %0d",
               lookup_cnt_o, hit_cnt_o, m_lk, m_hc);
    end
  endtask

  task automatic test_inval();
    logic [31:0] probe [5] = '{32'h40, 32'h440, 32'h48, 32'h4C, 32'h7C};
    drive_upd(32'h48, 1'b1, 32'h90);
    tick();
    drive_upd(32'h4C, 1'b1, 32'h99);
    inval_i = 1'b1;
    tick();
    idle();
    foreach (probe[k]) begin
      pc_i = probe[k];
      #1;
      checks++;
      if (hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
        errors++;
        $display("FAIL inval_miss pc=%h: hit=%0b taken=%0b tgt=%h want 0 0 0",
                 probe[k], hit_o, pred_taken_o, pred_target_o);
      end
    end
  endtask

  task automatic test_async_reset();
    pc_i = 32'h50;
    drive_upd(32'h50, 1'b1, 32'hA0);
    tick();
    idle();
    #1;
    checks++;
    if (hit_o !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_hit: hit=%0b want 1", hit_o);
    end
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (hit_o !== 1'b0 || pred_target_o !== 32'h0 || lookup_cnt_o !== 16'h0 ||
        hit_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: hit=%0b tgt=%h lookups=%0d hits=%0d want 0 0 0 0",
               hit_o, pred_target_o, lookup_cnt_o, hit_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_random(input int cycles);
    int bad = 0;
    for (int n = 0; n < cycles; n++) begin
      pc_i = rand_pc();
      upd_valid_i  = ($urandom_range(0, 99) < 60);
      upd_pc_i     = ($urandom_range(0, 3) == 0) ? pc_i : rand_pc();
      upd_taken_i  = $urandom_range(0, 1);
      upd_target_i = $urandom;
      upd_stall_i  = ($urandom_range(0, 99) < 15);
      inval_i      = ($urandom_range(0, 99) < 3);
      #1;
      checks++;
      if (hit_o !== m_hit(pc_i) || pred_taken_o !== m_taken(pc_i) ||
          pred_target_o !== m_target(pc_i)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_lookup pc=%h: hit=%0b taken=%0b tgt=%h want %0b %0b %h",
                   pc_i, hit_o, pred_taken_o, pred_target_o,
                   m_hit(pc_i), m_taken(pc_i), m_target(pc_i));
      end
      checks++;
      if (lookup_cnt_o !== 16'(m_lk) || hit_cnt_o !== 16'(m_hc)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_stats: lookups=%0d hits=%0d want %0d %0d",
                   lookup_cnt_o, hit_cnt_o, m_lk, m_hc);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_stats_saturate();
    idle();
    for (int n = 0; n < 70000; n++) begin
      pc_i = rand_pc();
      tick();
    end
    #1;
    checks++;
    if (lookup_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL lookup_saturate: lookups=%0d want 65535", lookup_cnt_o);
    end
    checks++;
    if (hit_cnt_o !== 16'(m_hc)) begin
      errors++;
      $display("FAIL hit_count: hits=%0d want %0d", hit_cnt_o, m_hc);
    end
  endtask

  initial begin
    test_reset();
    test_taken_alloc();
    test_counter_saturate();
    test_alias();
    test_same_cycle_and_stall();
    test_inval();
    test_async_reset();
    test_random(3000);
    test_stats_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
